hazard_stall_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage RV32I core. Generates per-stage

---
 rtl/hazard_stall_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Pipeline sequencer for the 5-stage RV32I core. Produces per-stage
//            enables and flushes from load-use hazards, taken branches resolved
//            in EX and multi-cycle APB accesses in MEM. Tracks APB wait time
//            with a timeout (bus error pulse) and keeps saturating stall/flush
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int APB_TIMEOUT = 16,   // max cycles spent in APB wait (>= 2)
    parameter int CNT_W       = 32    // performance counter width
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_addr_id,
    input  logic [4:0]       i_rs2_addr_id,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic [4:0]       i_rd_addr_ex,
    input  logic             i_load_ex,
    input  logic             i_pc_sel_ex,
    input  logic             i_apb_req_mem,
    input  logic             i_apb_done,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int                 c_TMO_W    = (APB_TIMEOUT > 2) ? $clog2(APB_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(APB_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_APB_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_in_run;
    logic w_in_wait;
    logic w_tmo_hit;
    logic w_apb_stall;
    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_branch;
    logic w_lu_stall;

    assign w_in_run  = (r_state == c_ST_RUN);
    assign w_in_wait = (r_state == c_ST_APB_WAIT);

    // Timeout fires on the last allowed wait cycle only if the slave is still silent;
    // a completion on that same cycle takes precedence and is not an error.
    assign w_tmo_hit   = w_in_wait & ~i_apb_done & (r_tmo_cnt == c_TMO_LAST);
    assign w_apb_stall = (w_in_run & i_apb_req_mem) | (w_in_wait & ~i_apb_done & ~w_tmo_hit);

    // x0 never carries a real dependency, so a load targeting it is ignored.
    assign w_rs1_hit  = i_rs1_used & (i_rs1_addr_id == i_rd_addr_ex);
    assign w_rs2_hit  = i_rs2_used & (i_rs2_addr_id == i_rd_addr_ex);
    assign w_load_use = i_load_ex & (i_rd_addr_ex != 5'd0) & (w_rs1_hit | w_rs2_hit);

    // Resolved priority cases: a freeze masks everything, a flush masks load-use.
    assign w_branch   = ~w_apb_stall & i_pc_sel_ex;
    assign w_lu_stall = ~w_apb_stall & ~i_pc_sel_ex & w_load_use;

    // APB wait sequencer and its timeout counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= c_ST_RUN;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_tmo_cnt <= '0;
                    if (i_apb_req_mem) begin
                        r_state <= c_ST_APB_WAIT;
                    end
                end
                c_ST_APB_WAIT: begin
                    if (i_apb_done || w_tmo_hit) begin
                        r_state   <= c_ST_RUN;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    end
                end
                default: begin
                    r_state   <= c_ST_RUN;
                    r_tmo_cnt <= '0;
                end
            endcase
        end
    end

    // Same-cycle stage controls; reset forces both flushes so every stage clears
    always_comb begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_en    = 1'b1;
        o_idex_flush = 1'b0;
        o_exmem_en   = 1'b1;
        if (i_reset) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_apb_stall) begin
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_en  = 1'b0;
            o_exmem_en = 1'b0;
        end else if (w_branch) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_lu_stall) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
        end
    end

    // A reset that lands on the timeout cycle abandons the access silently
    assign o_bus_err = w_tmo_hit & ~i_reset;

    // Saturating performance counters: stalls (APB freeze + load-use) and branch flushes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_apb_stall || w_lu_stall) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_branch && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed scoreboard bench for hazard_stall_ctrl (CNT_W=4 so that
//            counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    // control pattern: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    localparam logic [5:0] c_NORM = 6'b110101;
    localparam logic [5:0] c_FRZ  = 6'b000000;
    localparam logic [5:0] c_BR   = 6'b111111;
    localparam logic [5:0] c_LU   = 6'b000111;
    localparam logic [5:0] c_RST  = 6'b111111;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, pcs, req, done;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, bus_err;
    logic [3:0] stall_cnt, flush_cnt;

    typedef struct {
        string      name;
        logic [5:0] ctrl;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] act_ctrl;

    hazard_stall_ctrl #(.APB_TIMEOUT(16), .CNT_W(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_rs1_addr_id (rs1),
        .i_rs2_addr_id (rs2),
        .i_rs1_used    (u1),
        .i_rs2_used    (u2),
        .i_rd_addr_ex  (rd),
        .i_load_ex     (ld),
        .i_pc_sel_ex   (pcs),
        .i_apb_req_mem (req),
        .i_apb_done    (done),
        .o_pc_en       (pc_en),
        .o_ifid_en     (ifid_en),
        .o_ifid_flush  (ifid_flush),
        .o_idex_en     (idex_en),
        .o_idex_flush  (idex_flush),
        .o_exmem_en    (exmem_en),
        .o_bus_err     (bus_err),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is compared on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
            checks++;
            if ({act_ctrl, bus_err, stall_cnt, flush_cnt} !== {e.ctrl, e.err, e.sc, e.fc}) begin
                errors++;
                $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, expected ctrl=%b err=%b stall=%0d flush=%0d",
                         e.name, act_ctrl, bus_err, stall_cnt, flush_cnt, e.ctrl, e.err, e.sc, e.fc);
            end
        end
    end

    // Apply one cycle of inputs and queue the expected response for that cycle
    task automatic drive(input string nm, input logic r,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic v1, input logic v2, input logic [4:0] d,
                         input logic l, input logic p, input logic rq, input logic dn,
                         input logic [5:0] ec, input logic ee,
                         input logic [3:0] es, input logic [3:0] ef);
        exp_t x;
        rst = r; rs1 = a1; rs2 = a2; u1 = v1; u2 = v2; rd = d;
        ld = l; pcs = p; req = rq; done = dn;
        x.name = nm; x.ctrl = ec; x.err = ee; x.sc = es; x.fc = ef;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0;
        ld = 0; pcs = 0; req = 0; done = 0;
        @(posedge clk);
        #1;
        //     name            rst rs1 rs2 u1 u2 rd ld pc rq dn  ctrl  err st fl
        drive("reset",          1,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_RST, 0, 0, 0);
        drive("idle",           0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 0, 0);
        drive("load_use_rs1",   0,  5,  1, 1, 1, 5, 1, 0, 0, 0, c_LU,  0, 0, 0);
        drive("ld_rd_x0",       0,  0,  0, 1, 1, 0, 1, 0, 0, 0, c_NORM,0, 1, 0);
        drive("load_use_rs2",   0,  3,  7, 1, 1, 7, 1, 0, 0, 0, c_LU,  0, 1, 0);
        drive("rs2_unused",     0,  3,  7, 1, 0, 7, 1, 0, 0, 0, c_NORM,0, 2, 0);
        drive("no_load",        0,  5,  1, 1, 1, 5, 0, 0, 0, 0, c_NORM,0, 2, 0);
        drive("br_over_lu",     0,  5,  1, 1, 1, 5, 1, 1, 0, 0, c_BR,  0, 2, 0);
        drive("branch",         0,  0,  0, 0, 0, 0, 0, 1, 0, 0, c_BR,  0, 2, 1);
        drive("idle2",          0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 2, 2);
        // APB with completion after three wait cycles
        drive("apb_run",        0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 2, 2);
        drive("apb_wait1",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 3, 2);
        drive("apb_wait2",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 4, 2);
        drive("apb_wait3",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 5, 2);
        drive("apb_done",       0,  0,  0, 0, 0, 0, 0, 0, 1, 1, c_NORM,0, 6, 2);
        drive("apb_back_run",   0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 6, 2);
        drive("done_in_run",    0,  0,  0, 0, 0, 0, 0, 0, 0, 1, c_NORM,0, 6, 2);
        // release cycle carrying a taken branch, then back-to-back APB access
        drive("apb_run2",       0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 6, 2);
        drive("release_branch", 0,  0,  0, 0, 0, 0, 0, 1, 1, 1, c_BR,  0, 7, 2);
        drive("b2b_run",        0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 7, 3);
        drive("b2b_done",       0,  0,  0, 0, 0, 0, 0, 0, 0, 1, c_NORM,0, 8, 3);
        drive("b2b_idle",       0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 8, 3);
        // timeout: no completion, stall counter saturates along the way
        drive("tmo_run",        0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 8, 3);
        for (int k = 0; k < 15; k++)
            drive("tmo_wait",   0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, sat4(9 + k), 3);
        drive("tmo_bus_err",    0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_NORM,1, 15, 3);
        drive("tmo_after",      0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 15, 3);
        // reset lands on what would be the timeout cycle
        drive("rst_apb_run",    0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 15, 3);
        for (int k = 0; k < 15; k++)
            drive("rst_apb_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_FRZ, 0, 15, 3);
        drive("rst_in_wait",    1,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_RST, 0, 15, 3);
        drive("rst_release",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 0, 0);
        // flush counter saturation
        for (int k = 0; k < 17; k++)
            drive("flush_sat",  0,  5,  1, 1, 1, 5, 1, 1, 0, 0, c_BR,  0, 0, sat4(k));
        drive("flush_hold",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_NORM,0, 0, 15);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
